bp_cache_req_arbiter: RTL and testbench

//  Shares one cache-service engine (LCE/UCE request port) between the I$ (FE) and D$ (BE) miss paths of a

---
 rtl/bp_cache_req_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_bp_cache_req_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_req_arbiter.sv
// bp_cache_req_arbiter
// Shares one cache-service engine between the I$ (FE) and D$ (BE) miss paths.
// A round-robin arbiter picks a requester, holds that choice across any
// backpressure, then owns the engine for one whole transaction:
// request, then metadata, then complete. Only one transaction is in flight.
// The owner is exported so the mem-pkt responses can be routed to it.

module bp_cache_req_arbiter #(
    parameter int req_width_p          = 112,
    parameter int req_metadata_width_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [req_width_p-1:0]          icache_req_i,
    input  logic                            icache_req_v_i,
    output logic                            icache_req_ready_o,
    input  logic [req_metadata_width_p-1:0] icache_req_metadata_i,
    input  logic                            icache_req_metadata_v_i,
    output logic                            icache_req_complete_o,

    input  logic [req_width_p-1:0]          dcache_req_i,
    input  logic                            dcache_req_v_i,
    output logic                            dcache_req_ready_o,
    input  logic [req_metadata_width_p-1:0] dcache_req_metadata_i,
    input  logic                            dcache_req_metadata_v_i,
    output logic                            dcache_req_complete_o,

    output logic [req_width_p-1:0]          req_o,
    output logic                            req_v_o,
    input  logic                            req_ready_i,
    output logic [req_metadata_width_p-1:0] req_metadata_o,
    output logic                            req_metadata_v_o,
    input  logic                            req_complete_i,

    output logic [1:0]                      owner_o
);

    // Requester encodings are one-hot {dcache, icache}.
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_I    = 2'b01;
    localparam logic [1:0] SEL_D    = 2'b10;

    typedef enum logic [1:0] {
        e_ready     = 2'd0,
        e_wait_md   = 2'd1,
        e_wait_cmpl = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] lock_q,  lock_d;
    logic       last_grant_q, last_grant_d;   // 0 = I$ won last, 1 = D$ won last

    // Selected requester (request phase) and its steered signals
    logic [1:0]                      sel_s;
    logic [req_width_p-1:0]          sel_req_s;
    logic                            sel_v_s;
    logic [req_metadata_width_p-1:0] sel_md_s;
    logic                            sel_md_v_s;
    logic                            xfer_s;

    // Owner's metadata (metadata phase)
    logic [req_metadata_width_p-1:0] own_md_s;
    logic                            own_md_v_s;

    // Ungated output values, forced low while reset is held
    logic [req_width_p-1:0]          req_s;
    logic                            req_v_s;
    logic [req_metadata_width_p-1:0] req_md_s;
    logic                            req_md_v_s;
    logic                            icache_ready_s;
    logic                            dcache_ready_s;
    logic                            icache_cmpl_s;
    logic                            dcache_cmpl_s;

    // Pick the requester: a held lock wins, else the lone valid one, else alternate on a tie
    always_comb begin
        sel_s = SEL_NONE;
        if (state_q == e_ready) begin
            if (lock_q != SEL_NONE) begin
                sel_s = lock_q;
            end else if (icache_req_v_i && dcache_req_v_i) begin
                sel_s = last_grant_q ? SEL_I : SEL_D;
            end else if (icache_req_v_i) begin
                sel_s = SEL_I;
            end else if (dcache_req_v_i) begin
                sel_s = SEL_D;
            end else begin
                sel_s = SEL_NONE;
            end
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Steer the selected requester's request and metadata
    always_comb begin
        sel_req_s  = {req_width_p{1'b0}};
        sel_v_s    = 1'b0;
        sel_md_s   = {req_metadata_width_p{1'b0}};
        sel_md_v_s = 1'b0;
        case (sel_s)
            SEL_I: begin
                sel_req_s  = icache_req_i;
                sel_v_s    = icache_req_v_i;
                sel_md_s   = icache_req_metadata_i;
                sel_md_v_s = icache_req_metadata_v_i;
            end
            SEL_D: begin
                sel_req_s  = dcache_req_i;
                sel_v_s    = dcache_req_v_i;
                sel_md_s   = dcache_req_metadata_i;
                sel_md_v_s = dcache_req_metadata_v_i;
            end
            default: begin
                sel_req_s  = {req_width_p{1'b0}};
                sel_v_s    = 1'b0;
                sel_md_s   = {req_metadata_width_p{1'b0}};
                sel_md_v_s = 1'b0;
            end
        endcase
    end

    // Steer the current owner's metadata; a non-owner's metadata is never seen
    always_comb begin
        own_md_s   = {req_metadata_width_p{1'b0}};
        own_md_v_s = 1'b0;
        case (owner_q)
            SEL_I: begin
                own_md_s   = icache_req_metadata_i;
                own_md_v_s = icache_req_metadata_v_i;
            end
            SEL_D: begin
                own_md_s   = dcache_req_metadata_i;
                own_md_v_s = dcache_req_metadata_v_i;
            end
            default: begin
                own_md_s   = {req_metadata_width_p{1'b0}};
                own_md_v_s = 1'b0;
            end
        endcase
    end

    assign xfer_s = sel_v_s & req_ready_i;

    // Transaction FSM: next state, bookkeeping registers and ungated outputs
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        lock_d         = lock_q;
        last_grant_d   = last_grant_q;
        req_s          = {req_width_p{1'b0}};
        req_v_s        = 1'b0;
        req_md_s       = {req_metadata_width_p{1'b0}};
        req_md_v_s     = 1'b0;
        icache_ready_s = 1'b0;
        dcache_ready_s = 1'b0;
        icache_cmpl_s  = 1'b0;
        dcache_cmpl_s  = 1'b0;
        case (state_q)
            e_ready: begin
                req_s          = sel_req_s;
                req_v_s        = sel_v_s;
                req_md_s       = sel_md_s;
                icache_ready_s = sel_s[0] & req_ready_i;
                dcache_ready_s = sel_s[1] & req_ready_i;
                if (xfer_s) begin
                    owner_d      = sel_s;
                    last_grant_d = sel_s[1];
                    lock_d       = SEL_NONE;
                    if (sel_md_v_s) begin
                        // Metadata arriving with the request goes out immediately
                        req_md_v_s = 1'b1;
                        state_d    = e_wait_cmpl;
                    end else begin
                        state_d    = e_wait_md;
                    end
                end else if (sel_v_s) begin
                    // Stalled: keep this requester so valid never switches source
                    lock_d = sel_s;
                end else begin
                    lock_d = SEL_NONE;
                end
            end
            e_wait_md: begin
                req_md_s   = own_md_s;
                req_md_v_s = own_md_v_s;
                if (own_md_v_s) begin
                    state_d = e_wait_cmpl;
                end else begin
                    state_d = e_wait_md;
                end
            end
            e_wait_cmpl: begin
                if (req_complete_i) begin
                    icache_cmpl_s = owner_q[0];
                    dcache_cmpl_s = owner_q[1];
                    owner_d       = SEL_NONE;
                    state_d       = e_ready;
                end else begin
                    state_d       = e_wait_cmpl;
                end
            end
            default: begin
                state_d = e_ready;
                owner_d = SEL_NONE;
                lock_d  = SEL_NONE;
            end
        endcase
    end

    // State and bookkeeping registers, cleared immediately by reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= e_ready;
            owner_q      <= SEL_NONE;
            lock_q       <= SEL_NONE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lock_q       <= lock_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Drive outputs, holding every one low while reset is asserted
    always_comb begin
        if (reset_i) begin
            req_o                 = {req_width_p{1'b0}};
            req_v_o               = 1'b0;
            req_metadata_o        = {req_metadata_width_p{1'b0}};
            req_metadata_v_o      = 1'b0;
            icache_req_ready_o    = 1'b0;
            dcache_req_ready_o    = 1'b0;
            icache_req_complete_o = 1'b0;
            dcache_req_complete_o = 1'b0;
            owner_o               = SEL_NONE;
        end else begin
            req_o                 = req_s;
            req_v_o               = req_v_s;
            req_metadata_o        = req_md_s;
            req_metadata_v_o      = req_md_v_s;
            icache_req_ready_o    = icache_ready_s;
            dcache_req_ready_o    = dcache_ready_s;
            icache_req_complete_o = icache_cmpl_s;
            dcache_req_complete_o = dcache_cmpl_s;
            owner_o               = owner_q;
        end
    end

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Testbench for bp_cache_req_arbiter: directed scenarios followed by random
// traffic. A transaction-level model predicts every cycle's outputs into a
// queue; a separate monitor pops and compares on the falling edge.

module tb_bp_cache_req_arbiter;

    localparam int RW = 112;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [RW-1:0] icache_req_i, dcache_req_i, req_o;
    logic          icache_req_v_i, dcache_req_v_i, req_v_o;
    logic          icache_req_ready_o, dcache_req_ready_o;
    logic [MW-1:0] icache_req_metadata_i, dcache_req_metadata_i, req_metadata_o;
    logic          icache_req_metadata_v_i, dcache_req_metadata_v_i, req_metadata_v_o;
    logic          icache_req_complete_o, dcache_req_complete_o;
    logic          req_ready_i, req_complete_i;
    logic [1:0]    owner_o;

    bp_cache_req_arbiter #(.req_width_p(RW), .req_metadata_width_p(MW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .icache_req_i(icache_req_i), .icache_req_v_i(icache_req_v_i),
        .icache_req_ready_o(icache_req_ready_o),
        .icache_req_metadata_i(icache_req_metadata_i),
        .icache_req_metadata_v_i(icache_req_metadata_v_i),
        .icache_req_complete_o(icache_req_complete_o),
        .dcache_req_i(dcache_req_i), .dcache_req_v_i(dcache_req_v_i),
        .dcache_req_ready_o(dcache_req_ready_o),
        .dcache_req_metadata_i(dcache_req_metadata_i),
        .dcache_req_metadata_v_i(dcache_req_metadata_v_i),
        .dcache_req_complete_o(dcache_req_complete_o),
        .req_o(req_o), .req_v_o(req_v_o), .req_ready_i(req_ready_i),
        .req_metadata_o(req_metadata_o), .req_metadata_v_o(req_metadata_v_o),
        .req_complete_i(req_complete_i), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] req;
        logic          req_v;
        logic [MW-1:0] md;
        logic          md_v;
        logic [1:0]    ready;   // {d, i}
        logic [1:0]    cmpl;    // {d, i}
        logic [1:0]    owner;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle    = 0;

    // Transaction-level model: who owns the engine, what it waits for, who won last
    int m_phase = 0;   // 0 = free, 1 = awaiting metadata, 2 = awaiting complete
    int m_own   = 0;   // 0 = none, 1 = I$, 2 = D$
    int m_last  = 1;   // last winner; reset behaves as if I$ won
    int m_held  = 0;   // requester held across backpressure
    int m_acc   = 0;   // requester accepted this cycle

    task automatic chk(input string name, input int cyc, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare DUT outputs against the predicted cycle away from the clock edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_v_o", e.cyc, 128'(req_v_o), 128'(e.req_v));
            chk("req_o", e.cyc, 128'(req_o), 128'(e.req));
            chk("ready_o", e.cyc, 128'({dcache_req_ready_o, icache_req_ready_o}), 128'(e.ready));
            chk("md_v_o", e.cyc, 128'(req_metadata_v_o), 128'(e.md_v));
            if (e.md_v) chk("md_o", e.cyc, 128'(req_metadata_o), 128'(e.md));
            chk("complete_o", e.cyc, 128'({dcache_req_complete_o, icache_req_complete_o}), 128'(e.cmpl));
            chk("owner_o", e.cyc, 128'(owner_o), 128'(e.owner));
        end
    end

    // Drive one cycle of inputs, predict outputs, advance the model
    task automatic step(input bit rst,
                        input bit iv, input logic [RW-1:0] ir, input bit imv, input logic [MW-1:0] imd,
                        input bit dv, input logic [RW-1:0] dr, input bit dmv, input logic [MW-1:0] dmd,
                        input bit rdy, input bit cmpl);
        exp_t          e;
        bit            v  [3];
        bit            mv [3];
        logic [RW-1:0] rq [3];
        logic [MW-1:0] md [3];
        int            w;
        @(posedge clk);
        #1;
        reset_i = rst;
        icache_req_v_i = iv; icache_req_i = ir; icache_req_metadata_v_i = imv; icache_req_metadata_i = imd;
        dcache_req_v_i = dv; dcache_req_i = dr; dcache_req_metadata_v_i = dmv; dcache_req_metadata_i = dmd;
        req_ready_i = rdy; req_complete_i = cmpl;
        v[1] = iv; v[2] = dv; mv[1] = imv; mv[2] = dmv;
        rq[1] = ir; rq[2] = dr; md[1] = imd; md[2] = dmd;
        v[0] = 1'b0; mv[0] = 1'b0; rq[0] = '0; md[0] = '0;
        e = '0;
        e.cyc = cycle;
        m_acc = 0;
        if (rst) begin
            m_phase = 0; m_own = 0; m_last = 1; m_held = 0;
        end else begin
            e.owner = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
            if (m_phase == 0) begin
                if (m_held != 0)      w = m_held;
                else if (iv && dv)    w = (m_last == 1) ? 2 : 1;
                else if (iv)          w = 1;
                else if (dv)          w = 2;
                else                  w = 0;
                if (w != 0) begin
                    e.req_v = v[w];
                    e.req   = rq[w];
                    e.ready = (w == 1) ? {1'b0, rdy} : {rdy, 1'b0};
                end
                if (w != 0 && v[w] && rdy) begin
                    m_acc  = w;
                    e.md_v = mv[w];
                    e.md   = md[w];
                    m_own = w; m_last = w; m_held = 0;
                    m_phase = mv[w] ? 2 : 1;
                end else begin
                    m_held = (w != 0 && v[w]) ? w : 0;
                end
            end else if (m_phase == 1) begin
                e.md_v = mv[m_own];
                e.md   = md[m_own];
                if (mv[m_own]) m_phase = 2;
            end else begin
                if (cmpl) begin
                    e.cmpl  = (m_own == 1) ? 2'b01 : 2'b10;
                    m_own   = 0;
                    m_phase = 0;
                end
            end
        end
        exp_q.push_back(e);
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0, 0, '0, 0, '0, 0, 0);
    endtask

    function automatic logic [RW-1:0] rnd_req();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[RW-1:0];
    endfunction

    initial begin
        bit            pend [3];
        logic [RW-1:0] preq [3];
        bit            iv, dv;

        reset_i = 1'b1;
        icache_req_i = '0; icache_req_v_i = 1'b0; icache_req_metadata_i = '0; icache_req_metadata_v_i = 1'b0;
        dcache_req_i = '0; dcache_req_v_i = 1'b0; dcache_req_metadata_i = '0; dcache_req_metadata_v_i = 1'b0;
        req_ready_i = 1'b0; req_complete_i = 1'b0;

        // Reset: outputs low even with live requests and engine ready
        step(1, 1, 112'h55, 1, 4'h3, 1, 112'h66, 1, 4'h2, 1, 1);
        step(1, 0, '0, 0, '0, 0, '0, 0, '0, 0, 0);

        // Lone I$ transaction
        step(0, 1, 112'h1234, 0, '0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 4'h5, 0, '0, 0, '0, 0, 0);
        idle(4);
        step(0, 0, '0, 0, '0, 0, '0, 0, '0, 0, 1);

        // Tie after reset goes to D$, then alternates with both always valid
        step(1, 0, '0, 0, '0, 0, '0, 0, '0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            step(0, 1, 112'hA0 + 112'(t), 1, 4'h1, 1, 112'hB0 + 112'(t), 1, 4'h2, 1, 0);
            step(0, 1, 112'hA0 + 112'(t), 0, '0, 1, 112'hB0 + 112'(t), 0, '0, 0, 1);
        end
        step(1, 0, '0, 0, '0, 0, '0, 0, '0, 0, 0);

        // Backpressure: I$ held while D$ joins; then I$ transfers
        step(0, 1, 112'h111, 0, '0, 0, '0, 0, '0, 0, 0);
        for (int t = 0; t < 3; t++) step(0, 1, 112'h111, 0, '0, 1, 112'h222, 0, '0, 0, 0);
        step(0, 1, 112'h111, 0, '0, 1, 112'h222, 0, '0, 1, 0);
        step(0, 0, '0, 1, 4'h9, 1, 112'h222, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 1, 112'h222, 0, '0, 0, 1);

        // Same-cycle metadata for D$, then stray I$ metadata and complete while idle
        step(0, 0, '0, 0, '0, 1, 112'h222, 1, 4'hC, 1, 0);
        step(0, 0, '0, 1, 4'h7, 0, '0, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 4'h7, 0, '0, 0, '0, 0, 1);

        // Stray I$ metadata while D$ awaits metadata
        step(0, 0, '0, 0, '0, 1, 112'h333, 0, '0, 1, 0);
        step(0, 0, '0, 1, 4'hE, 0, '0, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 0, '0, 1, 4'h4, 0, 0);

        // Reset while awaiting complete; the late complete must not pulse
        step(1, 0, '0, 0, '0, 0, '0, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 112'h444, 1, 4'h8, 1, 0);
        step(0, 0, '0, 0, '0, 0, '0, 0, '0, 0, 1);

        // Random traffic with protocol-abiding requesters
        pend[0] = 0; pend[1] = 0; pend[2] = 0;
        preq[0] = '0; preq[1] = '0; preq[2] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 1; r <= 2; r++) begin
                if (!pend[r] && ($urandom_range(2) == 0)) begin
                    pend[r] = 1;
                    preq[r] = rnd_req();
                end
            end
            iv = pend[1];
            dv = pend[2];
            step(($urandom_range(299) == 0),
                 iv, iv ? preq[1] : rnd_req(), ($urandom_range(2) == 0), 4'($urandom()),
                 dv, dv ? preq[2] : rnd_req(), ($urandom_range(2) == 0), 4'($urandom()),
                 ($urandom_range(1) == 0), ($urandom_range(3) == 0));
            if (m_acc != 0) pend[m_acc] = 0;
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("queue_drained", cycle, 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
